// File: rtl/disp_credit_ctrl.sv
// Credit-based dispatch from a rename group into NUM_QUE in-order dispatch queues.
// Optional stall counter output enabled by defining DISP_CREDIT_STALL_CNT_EN.
module disp_credit_ctrl #(
    parameter int NUM_QUE   = 3,
    parameter int QUE_DEPTH = 8,
    parameter int WIDTH     = 4,
    parameter int DEQ_NUM   = 4,
    localparam int QW = (NUM_QUE > 1) ? $clog2(NUM_QUE) : 1,
    localparam int CW = $clog2(QUE_DEPTH + 1),
    localparam int DW = $clog2(DEQ_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_grp_vld,
    input  logic [WIDTH-1:0]         i_grp_mask,
    input  logic [WIDTH*QW-1:0]      i_grp_que,
    output logic                     o_grp_ready,
    output logic [NUM_QUE-1:0]       o_enq_vld,
    output logic [NUM_QUE*WIDTH-1:0] o_enq_req,
    input  logic [NUM_QUE*DW-1:0]    i_deq_cnt,
`ifdef DISP_CREDIT_STALL_CNT_EN
    output logic [31:0]              o_stall_cnt,
`endif
    output logic                     o_dbg_state,
    output logic [NUM_QUE*CW-1:0]    o_dbg_credit
);

    localparam int SW = CW + DW + 1;

    typedef enum logic {
        RUN  = 1'b0,
        PART = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         sent_q, sent_d;
    logic [WIDTH-1:0]         pend, disp;
    logic [NUM_QUE*WIDTH-1:0] req;
    logic                     ready;
    logic                     blocked, hit;
    logic [CW-1:0]            credit_q [NUM_QUE];
    logic [CW-1:0]            used     [NUM_QUE];
    logic [SW-1:0]            sum      [NUM_QUE];
    logic [CW-1:0]            credit_d [NUM_QUE];

    // In-order scan: the first pending slot that does not fit stops the whole scan.
    always_comb begin
        pend    = i_grp_vld ? (i_grp_mask & ~sent_q) : '0;
        disp    = '0;
        req     = '0;
        blocked = 1'b0;
        hit     = 1'b0;
        for (int q = 0; q < NUM_QUE; q++) begin
            used[q] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (pend[i] && !blocked) begin
                hit = 1'b0;
                for (int q = 0; q < NUM_QUE; q++) begin
                    if (i_grp_que[i*QW +: QW] == QW'(q)) begin
                        hit = 1'b1;
                        if (used[q] < credit_q[q]) begin
                            used[q]           = used[q] + 1'b1;
                            disp[i]           = 1'b1;
                            req[q*WIDTH + i]  = 1'b1;
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                end
                if (!hit) begin
                    blocked = 1'b1;
                end
            end
        end
        ready = i_grp_vld && (pend == disp);
    end

    // Outputs are forced low while reset is held, without waiting for a clock.
    always_comb begin
        o_grp_ready = rst && !i_flush && ready;
        o_enq_req   = (rst && !i_flush) ? req : '0;
        for (int q = 0; q < NUM_QUE; q++) begin
            o_enq_vld[q] = |o_enq_req[q*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        o_dbg_state = state_q;
        for (int q = 0; q < NUM_QUE; q++) begin
            o_dbg_credit[q*CW +: CW] = credit_q[q];
            sum[q] = SW'(credit_q[q]) - SW'(used[q]) + SW'(i_deq_cnt[q*DW +: DW]);
            if (sum[q] > SW'(QUE_DEPTH)) begin
                credit_d[q] = CW'(QUE_DEPTH);
            end else begin
                credit_d[q] = sum[q][CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < NUM_QUE; q++) begin
                credit_q[q] <= CW'(QUE_DEPTH);
            end
        end else if (i_flush) begin
            for (int q = 0; q < NUM_QUE; q++) begin
                credit_q[q] <= CW'(QUE_DEPTH);
            end
        end else begin
            for (int q = 0; q < NUM_QUE; q++) begin
                credit_q[q] <= credit_d[q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
        end
    end

    // sent_mask remembers slots already enqueued so a held group never re-sends them.
    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        if (i_flush) begin
            state_d = RUN;
            sent_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    sent_d = '0;
                    if (i_grp_vld && !ready) begin
                        sent_d  = disp;
                        state_d = PART;
                    end
                end
                PART: begin
                    if (i_grp_vld) begin
                        if (ready) begin
                            sent_d  = '0;
                            state_d = RUN;
                        end else begin
                            sent_d = sent_q | disp;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    sent_d  = '0;
                end
            endcase
        end
    end

`ifdef DISP_CREDIT_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stall_cnt <= '0;
        end else if (i_grp_vld && !ready && !i_flush) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_disp_credit_ctrl.sv
// Scoreboard bench for disp_credit_ctrl: driver pushes model expectations, monitor compares at negedge.
// Handshake: a group is held on i_grp_vld until o_grp_ready is seen high (or a flush drops it).
module tb_disp_credit_ctrl;
  localparam int NQ = 3;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int QW = 2;
  localparam int CW = 4;
  localparam int DW = 3;
  localparam int EW = NQ*CW + 1 + 1 + NQ + NQ*WIDTH;

  logic clk;
  logic rst;
  logic i_flush;
  logic i_grp_vld;
  logic [WIDTH-1:0] i_grp_mask;
  logic [WIDTH*QW-1:0] i_grp_que;
  logic o_grp_ready;
  logic [NQ-1:0] o_enq_vld;
  logic [NQ*WIDTH-1:0] o_enq_req;
  logic [NQ*DW-1:0] i_deq_cnt;
  logic o_dbg_state;
  logic [NQ*CW-1:0] o_dbg_credit;
`ifdef DISP_CREDIT_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] exp_stall_q[$];
`endif

  disp_credit_ctrl #(.NUM_QUE(NQ), .QUE_DEPTH(DEPTH), .WIDTH(WIDTH), .DEQ_NUM(4)) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(i_flush),
    .i_grp_vld(i_grp_vld),
    .i_grp_mask(i_grp_mask),
    .i_grp_que(i_grp_que),
    .o_grp_ready(o_grp_ready),
    .o_enq_vld(o_enq_vld),
    .o_enq_req(o_enq_req),
    .i_deq_cnt(i_deq_cnt),
`ifdef DISP_CREDIT_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_dbg_state(o_dbg_state),
    .o_dbg_credit(o_dbg_credit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  // reference model state
  int m_credit[NQ];
  logic [WIDTH-1:0] m_sent;
  bit m_part;
  logic [31:0] m_stall;
  bit last_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) m_credit[q] = DEPTH;
    m_sent = '0;
    m_part = 1'b0;
    m_stall = '0;
  endtask

  function automatic logic [NQ*CW-1:0] pack_credit();
    logic [NQ*CW-1:0] c;
    c = '0;
    for (int q = 0; q < NQ; q++) c[q*CW +: CW] = CW'(m_credit[q]);
    return c;
  endfunction

  // driver: applies one cycle of stimulus and records what the model expects
  task automatic drive(input bit vld, input logic [3:0] mask, input logic [7:0] que,
                       input logic [8:0] deq, input bit flush);
    int used[NQ];
    logic [3:0] pend;
    logic [3:0] d;
    logic [11:0] req;
    logic [2:0] ev;
    bit rdy;
    bit stop;
    int q;
    @(posedge clk);
    #1;
    i_grp_vld = vld;
    i_grp_mask = mask;
    i_grp_que = que;
    i_deq_cnt = deq;
    i_flush = flush;
    pend = vld ? (mask & ~m_sent) : 4'b0;
    d = '0;
    req = '0;
    stop = 1'b0;
    for (int k = 0; k < NQ; k++) used[k] = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend[i] && !stop) begin
        q = int'(que[i*QW +: QW]);
        if (q < NQ && used[q] < m_credit[q]) begin
          used[q]++;
          d[i] = 1'b1;
          req[q*WIDTH + i] = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
    rdy = vld && (pend == d);
    if (flush) req = '0;
    for (int k = 0; k < NQ; k++) ev[k] = |req[k*WIDTH +: WIDTH];
    exp_q.push_back({pack_credit(), m_part, rdy && !flush, ev, req});
`ifdef DISP_CREDIT_STALL_CNT_EN
    exp_stall_q.push_back(m_stall);
`endif
    if (vld && !rdy && !flush) m_stall = m_stall + 32'd1;
    if (flush) begin
      for (int k = 0; k < NQ; k++) m_credit[k] = DEPTH;
      m_sent = '0;
      m_part = 1'b0;
    end else begin
      for (int k = 0; k < NQ; k++) begin
        m_credit[k] = m_credit[k] - used[k] + int'(deq[k*DW +: DW]);
        if (m_credit[k] > DEPTH) m_credit[k] = DEPTH;
      end
      if (!m_part) begin
        if (vld && !rdy) begin
          m_sent = d;
          m_part = 1'b1;
        end
      end else if (vld) begin
        if (rdy) begin
          m_sent = '0;
          m_part = 1'b0;
        end else begin
          m_sent = m_sent | d;
        end
      end
    end
    last_rdy = rdy;
  endtask

  // monitor: compares DUT outputs against the oldest expectation
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("enq_req", 64'(o_enq_req), 64'(e[11:0]));
        check("enq_vld", 64'(o_enq_vld), 64'(e[14:12]));
        check("grp_ready", 64'(o_grp_ready), 64'(e[15]));
        check("state", 64'(o_dbg_state), 64'(e[16]));
        check("credit", 64'(o_dbg_credit), 64'(e[28:17]));
`ifdef DISP_CREDIT_STALL_CNT_EN
        if (exp_stall_q.size() > 0) check("stall_cnt", 64'(o_stall_cnt), 64'(exp_stall_q.pop_front()));
`endif
      end
    end
  end

  initial begin
    bit active;
    logic [3:0] g_mask;
    logic [7:0] g_que;
    logic [8:0] deq;
    bit vld;
    bit fl;
    int maxd;
    n_checks = 0;
    n_pass = 0;
    last_rdy = 1'b0;
    rst = 1'b0;
    i_flush = 1'b0;
    i_grp_vld = 1'b0;
    i_grp_mask = '0;
    i_grp_que = '0;
    i_deq_cnt = '0;
    model_reset();
    #12;
    check("rst_enq_vld", 64'(o_enq_vld), 64'd0);
    check("rst_ready", 64'(o_grp_ready), 64'd0);
    check("rst_credit", 64'(o_dbg_credit), 64'h888);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // mixed routing: q0 gets slots 0,3; q1 slot 1; q2 slot 2
    drive(1, 4'hF, 8'h24, 9'd0, 0);
    drive(0, 4'h0, 8'h00, 9'd0, 0);
    // trickle q0 credit down to 1, then drain a 4-slot q0 group across three cycles
    drive(1, 4'hF, 8'h00, 9'd0, 0);
    drive(1, 4'h1, 8'h00, 9'd0, 0);
    drive(1, 4'hF, 8'h00, 9'd2, 0);
    drive(1, 4'hF, 8'h00, 9'd1, 0);
    drive(1, 4'hF, 8'h00, 9'd0, 0);
    // partial group then flush, re-present from slot 0
    drive(0, 4'h0, 8'h00, 9'd2, 0);
    drive(1, 4'hF, 8'h00, 9'd0, 0);
    drive(1, 4'hF, 8'h00, 9'd0, 1);
    drive(1, 4'hF, 8'h00, 9'd0, 0);
    // q1 empty of credit blocks later slots despite q0 credit
    drive(1, 4'hF, 8'h55, 9'd0, 0);
    drive(1, 4'hF, 8'h55, 9'd0, 0);
    drive(1, 4'hF, 8'h04, 9'd0, 0);
    drive(1, 4'hF, 8'h04, 9'd0, 0);
    drive(1, 4'hF, 8'h04, 9'd8, 0);
    drive(1, 4'hF, 8'h04, 9'd0, 0);
    // empty mask is accepted immediately
    drive(1, 4'h0, 8'h00, 9'd0, 0);
    drive(0, 4'h0, 8'h00, 9'd0, 0);
    // enter PART on q2, then async reset between edges
    drive(1, 4'hF, 8'hAA, 9'd0, 0);
    drive(1, 4'h7, 8'hAA, 9'd0, 0);
    drive(1, 4'hF, 8'hAA, 9'd0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_enq_req", 64'(o_enq_req), 64'd0);
    check("arst_ready", 64'(o_grp_ready), 64'd0);
    check("arst_state", 64'(o_dbg_state), 64'd0);
    check("arst_credit", 64'(o_dbg_credit), 64'h888);
`ifdef DISP_CREDIT_STALL_CNT_EN
    check("arst_stall", 64'(o_stall_cnt), 64'd0);
`endif
    i_grp_vld = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();

    // randomized traffic
    active = 1'b0;
    g_mask = '0;
    g_que = '0;
    for (int n = 0; n < 800; n++) begin
      if (!active) begin
        vld = ($urandom_range(3, 0) != 0);
        g_mask = 4'($urandom_range(15, 0));
        for (int i = 0; i < WIDTH; i++) g_que[i*QW +: QW] = 2'($urandom_range(2, 0));
      end else begin
        vld = 1'b1;
      end
      deq = '0;
      for (int q = 0; q < NQ; q++) begin
        maxd = DEPTH - m_credit[q];
        if (maxd > 4) maxd = 4;
        deq[q*DW +: DW] = 3'($urandom_range(maxd, 0));
      end
      fl = ($urandom_range(19, 0) == 0);
      drive(vld, g_mask, g_que, deq, fl);
      active = vld && !fl && !last_rdy;
    end

    @(posedge clk);
    #1;
    i_grp_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/disp_credit_ctrl.md
Name: disp_credit_ctrl

Overview:
Credit-based dispatch controller between rename and the per-class dispatch queues (int/mem/fp), each an in-order fifo with unordered enqueue.
- Tracks free entries of every downstream queue with a credit counter.
- Routes each slot of the renamed group to its target queue.
- Dispatches the longest in-order prefix that fits, holding the group across cycles until every valid slot has been sent.

Parameters:
NUM_QUE, 3, number of downstream dispatch queues
QUE_DEPTH, 8, entries per queue; credit reset value
WIDTH, 4, slots per rename group (= queue INPORT_NUM)
DEQ_NUM, 4, max dequeues per queue per cycle (= queue OUTPORT_NUM)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_flush  in  1  pipeline flush; downstream queues are flushed the same cycle
i_grp_vld  in  1  renamed group present; held stable while o_grp_ready=0
i_grp_mask  in  WIDTH  valid slots of group
i_grp_que  in  WIDTH*$clog2(NUM_QUE)  target queue index per slot, slot i at [i*QW +: QW]
o_grp_ready  out  1  all valid slots dispatched this cycle; upstream may advance
o_enq_vld  out  NUM_QUE  enqueue strobe per queue
o_enq_req  out  NUM_QUE*WIDTH  bit q*WIDTH+i: slot i enqueued into queue q
i_deq_cnt  in  NUM_QUE*$clog2(DEQ_NUM+1)  entries dequeued from each queue this cycle

Behaviour:
- Reset (rst=0, async): credit[q]=QUE_DEPTH; sent_mask=0; state=RUN; o_enq_vld=0, o_enq_req=0, o_grp_ready=0.
- pend = i_grp_vld ? (i_grp_mask & ~sent_mask) : 0.
- Dispatch: scan pend slots from 0 upward, accumulating need[q].
  - Stop at the first slot whose need[q] would exceed credit[q].
  - Later slots are never sent, even if their queues have credit (strict in-order).
  - Dispatched set D is combinational, same cycle.
- o_enq_req bit q*WIDTH+i = D[i] and que[i]==q. o_enq_vld[q] = |(that queue's slice).
- o_grp_ready = i_grp_vld & (pend == D). An empty mask gives ready=1 at once.
- Credit update on posedge: credit[q] <= credit[q] - |D to q| + i_deq_cnt[q].
  - Dequeues become visible next cycle only; no same-cycle bypass.
  - Counter width $clog2(QUE_DEPTH+1).
  - Result above QUE_DEPTH is an illegal input; saturate at QUE_DEPTH.
- FSM:
  - RUN: if i_grp_vld & !o_grp_ready, sent_mask <= D, go PART. Otherwise sent_mask stays 0.
  - PART: sent_mask <= sent_mask | D. When o_grp_ready, sent_mask <= 0 and go RUN.
  - PART with i_grp_vld=0 is illegal; hold state.
- i_flush (highest priority):
  - o_enq_vld=0, o_enq_req=0, o_grp_ready=0 that cycle.
  - Next cycle: credits=QUE_DEPTH, sent_mask=0, state=RUN. i_deq_cnt ignored.
- Simultaneous enq and deq on an empty-credit queue: credit=0 blocks enq that cycle; deq restores credit next cycle.
- A slot is never enqueued twice. Total dispatched per queue never exceeds QUE_DEPTH outstanding.

Optional Feature:
DISP_CREDIT_STALL_CNT_EN:
- Defined: adds output o_stall_cnt [31:0], reset 0.
- Increments on each cycle with i_grp_vld & !o_grp_ready & !i_flush; wraps at 2^32.
- Flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, credits 8/8/8; group mask=1111, que={0,1,2,0} -> o_enq_req q0=1001, q1=0010, q2=0100; ready=1; next credits 6/7/7.
- q0 credit=1; group mask=1111 all q0 -> cyc0: slot0, ready=0, deq_cnt q0=2 -> cyc1: slots1,2, ready=0, deq 1 -> cyc2: slot3, ready=1, state RUN.
- q1 credit=0, q0 credit=8; mask=1111, que={0,1,0,0} -> only slot0 sent, ready=0; stays blocked until q1 deq_cnt=1, then slots1-3 sent next cycle, ready=1.
- In PART with sent_mask=0011, assert i_flush -> no enq that cycle; next cycle credits 8/8/8, sent_mask=0; re-presented group dispatches from slot0.
- Async rst low mid-PART between edges -> outputs 0 immediately; after release credits=8, state RUN.
- Mask=0000 with i_grp_vld=1 -> ready=1, no enq, credits unchanged; with DISP_CREDIT_STALL_CNT_EN, 3 blocked cycles -> o_stall_cnt=3.
